// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I core: sequences FETCH/DECODE/EXECUTE/MEM/WB,
// drives datapath selects, write strobes and the memory handshake, and counts retired instructions.
module multicycle_control #(
    parameter int unsigned RESET_STATE_FETCH = 1,
    parameter int unsigned INSTRET_W         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic                 branch_taken,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_addr_sel,
    output logic                 ir_we,
    output logic [1:0]           aluop,
    output logic [1:0]           alu_a_sel,
    output logic [1:0]           alu_b_sel,
    output logic                 reg_we,
    output logic [1:0]           wb_sel,
    output logic                 pc_we,
    output logic                 pc_src,
    output logic                 illegal,
    output logic                 halted,
    output logic [INSTRET_W-1:0] instret
);

    if (RESET_STATE_FETCH != 1) begin : g_reset_state_check
        $error("RESET_STATE_FETCH must be 1");
    end

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_BRTGT, S_TRAP, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        C_OP, C_OPIMM, C_LUI, C_AUIPC, C_JAL, C_JALR,
        C_BRANCH, C_LOAD, C_STORE, C_SYSTEM, C_ILLEGAL
    } class_e;

    state_e                 state_q, state_d;
    class_e                 class_q, class_d;
    logic                   taken_q, taken_d;
    logic                   illegal_q, illegal_d;
    logic                   halted_q, halted_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic                   retire;
    logic                   unused_instr;

    assign unused_instr = ^instr[31:7];

    function automatic class_e decode_class(input logic [6:0] op);
        case (op)
            7'b0110011: decode_class = C_OP;
            7'b0010011: decode_class = C_OPIMM;
            7'b0110111: decode_class = C_LUI;
            7'b0010111: decode_class = C_AUIPC;
            7'b1101111: decode_class = C_JAL;
            7'b1100111: decode_class = C_JALR;
            7'b1100011: decode_class = C_BRANCH;
            7'b0000011: decode_class = C_LOAD;
            7'b0100011: decode_class = C_STORE;
            7'b1110011: decode_class = C_SYSTEM;
            default:    decode_class = C_ILLEGAL;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        halted_d  = halted_q;
        retire    = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                class_d = decode_class(instr[6:0]);
                case (class_d)
                    C_ILLEGAL: begin state_d = S_TRAP; illegal_d = 1'b1; end
                    C_SYSTEM:  begin state_d = S_HALT; halted_d  = 1'b1; end
                    default:   state_d = S_EXECUTE;
                endcase
            end
            S_EXECUTE: begin
                taken_d = branch_taken;
                case (class_q)
                    C_OP, C_OPIMM, C_LUI, C_AUIPC, C_JAL, C_JALR: state_d = S_WB;
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_BRANCH:        state_d = S_BRTGT;
                    default: begin state_d = S_TRAP; illegal_d = 1'b1; end
                endcase
            end
            S_MEM: if (mem_ready) begin
                state_d = (class_q == C_STORE) ? S_FETCH : S_WB;
                retire  = (class_q == C_STORE);
            end
            S_WB, S_BRTGT: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = state_q;
        endcase
        instret_d = retire ? instret_q + 1'b1 : instret_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            class_q   <= C_OP;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
            instret_q <= instret_d;
        end
    end

    // Outputs depend only on state/class (plus the handshake in FETCH/MEM); rst masks all of them.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        aluop        = 2'b00;
        alu_a_sel    = 2'b00;
        alu_b_sel    = 2'b00;
        reg_we       = 1'b0;
        wb_sel       = 2'b00;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_EXECUTE: case (class_q)
                C_OP:     aluop = 2'b10;
                C_OPIMM:  begin aluop = 2'b11; alu_b_sel = 2'b01; end
                C_LUI:    begin alu_a_sel = 2'b10; alu_b_sel = 2'b01; end
                C_AUIPC:  begin alu_a_sel = 2'b01; alu_b_sel = 2'b01; end
                C_LOAD, C_STORE: alu_b_sel = 2'b01;
                C_JAL:    begin alu_a_sel = 2'b01; alu_b_sel = 2'b01; pc_we = 1'b1; pc_src = 1'b1; end
                C_JALR:   begin alu_b_sel = 2'b01; pc_we = 1'b1; pc_src = 1'b1; end
                C_BRANCH: begin aluop = 2'b01; pc_we = 1'b1; end
                default:  ;
            endcase
            S_BRTGT: begin
                alu_a_sel = 2'b01;
                alu_b_sel = 2'b01;
                pc_we     = taken_q;
                pc_src    = taken_q;
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (class_q == C_STORE);
                pc_we        = mem_ready && (class_q == C_STORE);
            end
            S_WB: begin
                reg_we = 1'b1;
                if (class_q == C_LOAD) wb_sel = 2'b01;
                else if (class_q == C_JAL || class_q == C_JALR) wb_sel = 2'b10;
                pc_we = !(class_q == C_JAL || class_q == C_JALR);
            end
            default: ;
        endcase
        if (rst) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_we        = 1'b0;
            aluop        = 2'b00;
            alu_a_sel    = 2'b00;
            alu_b_sel    = 2'b00;
            reg_we       = 1'b0;
            wb_sel       = 2'b00;
            pc_we        = 1'b0;
            pc_src       = 1'b0;
        end
    end

    assign illegal = illegal_q;
    assign halted  = halted_q;
    assign instret = instret_q;

endmodule
